// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: one state per clock,
// plus retired-instruction counter, illegal-instruction pulse and state debug.
module mips_multicycle_control #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode_i,
  input  logic [5:0]             funct_i,
  input  logic                   zero_i,
  output logic                   PCWrite,
  output logic                   IorD,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [3:0]             ALUControl,
  output logic                   PCSrc,
  output logic                   illegal_o,
  output logic [3:0]             state_o,
  output logic [COUNT_WIDTH-1:0] instr_count_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_e                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   retire;
  logic                   pcw, memw, irw, regw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    illegal_d  = 1'b0;
    retire     = 1'b0;
    pcw        = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    regw       = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    PCSrc      = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        irw     = 1'b1;
        pcw     = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ALUSrcB = 2'b11;
        case (opcode_i)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXECUTE;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        regw     = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        IorD   = 1'b1;
        memw   = 1'b1;
        retire = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        state_d = S_ALUWB;
        // Unknown funct still completes as an add; the flag reports it.
        case (funct_i)
          FN_ADD:  ALUControl = ALU_ADD;
          FN_SUB:  ALUControl = ALU_SUB;
          FN_AND:  ALUControl = ALU_AND;
          FN_OR:   ALUControl = ALU_OR;
          FN_SLT:  ALUControl = ALU_SLT;
          default: illegal_d  = 1'b1;
        endcase
      end
      S_ALUWB: begin
        RegDst = 1'b1;
        regw   = 1'b1;
        retire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        PCSrc      = 1'b1;
        pcw        = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
        retire     = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regw   = 1'b1;
        retire = 1'b1;
      end
      default: ALUSrcB = 2'b01;
    endcase
  end

  assign cnt_d = cnt_q + {{(COUNT_WIDTH-1){1'b0}}, retire};

  // Enables are gated by the reset pin so nothing writes while it is low.
  assign PCWrite  = pcw  & reset;
  assign MemWrite = memw & reset;
  assign IRWrite  = irw  & reset;
  assign RegWrite = regw & reset;

  assign illegal_o     = illegal_q;
  assign state_o       = state_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed + randomized bench for mips_multicycle_control against a per-instruction path model.
module tb_mips_multicycle_control;
  localparam int CW = 4;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode_i, funct_i;
  logic zero_i;
  logic PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUControl, state_o;
  logic illegal_o;
  logic [CW-1:0] instr_count_o;

  mips_multicycle_control #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .funct_i(funct_i), .zero_i(zero_i),
    .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .illegal_o(illegal_o),
    .state_o(state_o), .instr_count_o(instr_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, iord, memw, irw, regdst, memtoreg, regw, srca;
    logic [1:0] srcb;
    logic [3:0] aluc;
    logic pcsrc;
  } ctl_t;

  int n_tests = 0, n_fail = 0;
  int retired = 0;
  logic pend_ill = 1'b0;

  function automatic logic legal_op(logic [5:0] op);
    return op inside {RT, LW, SW, BEQ, BNE, ADDI};
  endfunction

  function automatic logic legal_fn(logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  function automatic logic [3:0] alu_of(logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected control word for a given phase of an instruction.
  function automatic ctl_t exp_ctl(int st, logic [5:0] op, logic [5:0] fn, logic z);
    ctl_t e;
    e = '0;
    e.st = 4'(st);
    e.aluc = 4'b0010;
    case (st)
      0: begin e.srcb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1; end
      1: e.srcb = 2'b11;
      2: begin e.srca = 1'b1; e.srcb = 2'b10; end
      3: e.iord = 1'b1;
      4: begin e.memtoreg = 1'b1; e.regw = 1'b1; end
      5: begin e.iord = 1'b1; e.memw = 1'b1; end
      6: begin e.srca = 1'b1; e.aluc = alu_of(fn); end
      7: begin e.regdst = 1'b1; e.regw = 1'b1; end
      8: begin e.srca = 1'b1; e.aluc = 4'b0110; e.pcsrc = 1'b1; e.pcw = (op == BNE) ? !z : z; end
      9: begin e.srca = 1'b1; e.srcb = 2'b10; end
      10: e.regw = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t obs_ctl();
    ctl_t o;
    o = '{st: state_o, pcw: PCWrite, iord: IorD, memw: MemWrite, irw: IRWrite,
          regdst: RegDst, memtoreg: MemtoReg, regw: RegWrite, srca: ALUSrcA,
          srcb: ALUSrcB, aluc: ALUControl, pcsrc: PCSrc};
    return o;
  endfunction

  task automatic chk_ctl(string tag, ctl_t e);
    ctl_t o;
    o = obs_ctl();
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s ctl: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic chk1(string tag, logic o, logic e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic chk_cnt(string tag);
    logic [CW-1:0] e;
    e = CW'(retired % (1 << CW));
    n_tests++;
    assert (instr_count_o === e) else begin
      n_fail++;
      $error("FAIL %s count: observed %0d expected %0d", tag, instr_count_o, e);
    end
  endtask

  // Called while the DUT is in FETCH, away from the clock edge; returns in the next FETCH.
  task automatic run_instr(string tag, logic [5:0] op, logic [5:0] fn, logic z);
    int q[$];
    logic bad_fn, e_ill;
    opcode_i = op; funct_i = fn; zero_i = z;
    case (op)
      LW:       q = '{0, 1, 2, 3, 4};
      SW:       q = '{0, 1, 2, 5};
      RT:       q = '{0, 1, 6, 7};
      BEQ, BNE: q = '{0, 1, 8};
      ADDI:     q = '{0, 1, 9, 10};
      default:  q = '{0, 1};
    endcase
    bad_fn = (op == RT) && !legal_fn(fn);
    for (int i = 0; i < q.size(); i++) begin
      chk_ctl(tag, exp_ctl(q[i], op, fn, z));
      e_ill = (i == 0) ? pend_ill : (bad_fn && i == 3);
      chk1({tag, " illegal"}, illegal_o, e_ill);
      chk_cnt(tag);
      @(posedge clk); #1;
    end
    pend_ill = !legal_op(op);
    if (legal_op(op)) retired++;
  endtask

  initial begin
    logic [5:0] op, fn;
    int r;
    reset = 1'b0; opcode_i = '0; funct_i = '0; zero_i = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk1("rst state0", state_o == 4'd0, 1'b1);
      chk1("rst PCWrite", PCWrite, 1'b0);
      chk1("rst IRWrite", IRWrite, 1'b0);
      chk1("rst MemWrite", MemWrite, 1'b0);
      chk1("rst RegWrite", RegWrite, 1'b0);
      chk1("rst illegal", illegal_o, 1'b0);
      chk_cnt("rst");
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b1; #1;

    run_instr("addi", ADDI, 6'h00, 1'b0);
    run_instr("lw", LW, 6'h00, 1'b0);
    run_instr("sw", SW, 6'h00, 1'b0);
    run_instr("beq z1", BEQ, 6'h00, 1'b1);
    run_instr("bne z1", BNE, 6'h00, 1'b1);
    run_instr("beq z0", BEQ, 6'h00, 1'b0);
    run_instr("bne z0", BNE, 6'h00, 1'b0);
    run_instr("slt", RT, 6'b101010, 1'b0);
    run_instr("badfn", RT, 6'b111111, 1'b0);
    run_instr("badop", 6'b111111, 6'h00, 1'b0);
    run_instr("after badop", RT, 6'b100000, 1'b0);

    // Abandon a lw in MEMRD with an asynchronous reset pulse.
    opcode_i = LW; funct_i = '0; zero_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("lw abort", exp_ctl(i, LW, 6'h00, 1'b0));
      @(posedge clk); #1;
    end
    chk_ctl("lw abort memrd", exp_ctl(3, LW, 6'h00, 1'b0));
    #2 reset = 1'b0; #1;
    chk1("async rst state0", state_o == 4'd0, 1'b1);
    chk1("async rst RegWrite", RegWrite, 1'b0);
    chk1("async rst PCWrite", PCWrite, 1'b0);
    chk1("async rst IRWrite", IRWrite, 1'b0);
    @(posedge clk); #1;
    chk1("held rst state0", state_o == 4'd0, 1'b1);
    chk1("held rst RegWrite", RegWrite, 1'b0);
    retired = 0;
    pend_ill = 1'b0;
    chk_cnt("after rst");
    @(negedge clk); reset = 1'b1; #1;
    run_instr("post rst addi", ADDI, 6'h00, 1'b0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 6);
      case (r)
        0: op = RT;
        1: op = LW;
        2: op = SW;
        3: op = BEQ;
        4: op = BNE;
        5: op = ADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          for (int k = 0; k < 64 && legal_op(op); k++) op = op + 6'd1;
        end
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'b100000;
        1: fn = 6'b100010;
        2: fn = 6'b100100;
        3: fn = 6'b100101;
        4: fn = 6'b101010;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run_instr("rand", op, fn, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore-style control FSM that drives every control input of the multicycle MIPS datapath.
- Takes the opcode and funct fields from the datapath's instruction register, plus the ALU zero flag.
- Sequences fetch, decode, execute, memory and writeback one state per clock.
- Also provides a retired-instruction counter, an illegal-instruction flag and a state debug output.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode_i  input  6  Instr[31:26] from the datapath instruction register.
- funct_i  input  6  Instr[5:0].
- zero_i  input  1  ALU result == 0, combinational from the datapath.
- PCWrite  output  1  PC register enable.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  memory write enable.
- IRWrite  output  1  instruction register enable.
- RegDst  output  1  write-register select: 0 = rt, 1 = rd.
- MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = Data.
- RegWrite  output  1  register-file write enable.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- PCSrc  output  1  next-PC select: 0 = ALUResult, 1 = ALUOut.
- illegal_o  output  1  one-cycle pulse on an unsupported opcode or funct.
- state_o  output  4  current state encoding.
- instr_count_o  output  COUNT_WIDTH  retired instructions; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (reset low, asynchronous):
  - state = FETCH (0); instr_count_o = 0; illegal_o = 0.
  - All write enables (PCWrite, IRWrite, MemWrite, RegWrite) are forced to 0 for as long as reset is low.
  - Reset asserted mid-instruction abandons the instruction; no partial write may follow the release.
- First cycle after release is FETCH.
- Outputs are decoded from the state register only, with two exceptions: PCWrite in BRANCH and ALUControl in EXECUTE.
- Any output not listed for a state is 0, except ALUControl, which defaults to ADD.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000.
- Supported R-type funct: add 100000 -> ADD, sub 100010 -> SUB, and 100100 -> AND, or 100101 -> OR, slt 101010 -> SLT.
- States (encoding) -> outputs -> next state:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=0, IRWrite=1, PCWrite=1 -> DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut) -> by opcode:
    - lw, sw -> MEMADR
    - R-type -> EXECUTE
    - beq, bne -> BRANCH
    - addi -> ADDIEX
    - otherwise -> FETCH, with illegal_o=1 in the following cycle.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ADD -> lw: MEMRD; sw: MEMWR.
  - MEMRD(3): IorD=1 -> MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
  - MEMWR(5): IorD=1, MemWrite=1 -> FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUControl from funct -> ALUWB.
    - Unknown funct: ALUControl=ADD; illegal_o pulses; the instruction still completes.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=1 -> FETCH.
    - PCWrite = zero_i for beq, ~zero_i for bne.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB.
  - ADDIWB(10): RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
  - Encodings 11-15: outputs as FETCH with all enables 0 -> FETCH next cycle.
- Latencies:
  - lw: 5 cycles.
  - R-type, sw, addi: 4 cycles.
  - beq, bne: 3 cycles.
  - illegal opcode: 2 cycles.
- instr_count_o increments by 1 on the clock edge that leaves MEMWB, MEMWR, ALUWB, BRANCH or ADDIWB for FETCH.
  - It does not increment on illegal-opcode aborts.
  - It wraps from all-ones to 0.
- opcode_i and funct_i are sampled every cycle; they are stable after FETCH because IRWrite is asserted only in FETCH.

Test Plan:
- Hold reset low 3 cycles, then release -> all enables 0 during reset; state_o=0, PCWrite=1, IRWrite=1 in the first cycle; state_o=1 next.
- addi (opcode 001000) -> state_o sequence 0,1,9,10,0; RegWrite=1 only in state 10 with RegDst=0; instr_count_o 0 -> 1.
- lw then sw -> lw: 0,1,2,3,4 with MemtoReg=1, RegWrite=1 in state 4; sw: 0,1,2,5 with MemWrite=1, IorD=1 in state 5; count = 2.
- beq with zero_i=1, then bne with zero_i=1 -> PCWrite=1, PCSrc=1, ALUControl=0110 in state 8 for beq; PCWrite=0 in state 8 for bne.
- R-type with funct 101010, then funct 111111 -> ALUControl=0111 in EXECUTE; then ALUControl=0010 with illegal_o pulsing 1 cycle; both reach ALUWB with RegDst=1.
- Opcode 111111 -> 0,1,0 with illegal_o=1 for one cycle, count unchanged; reset pulsed low during MEMRD -> state_o=0 immediately (asynchronous), RegWrite never asserted.
